// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, reset/write polarities and
// the redirect alignment helper used by if_fetch and if_icache.
package if_fetch_pkg;

    localparam int               InstAddrBus = 32;
    localparam int               InstBus     = 32;
    localparam logic [InstBus-1:0] ZeroWord  = '0;
    localparam logic             RstEnable   = 1'b1;
    localparam logic             WriteEnable = 1'b1;

    // Instructions are word aligned; redirect targets are forced onto a word.
    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
        return {a[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache of one-word lines, indexed by word address.
// Asynchronous lookup, synchronous fill; valid bits cleared by reset only.
module if_icache
    import if_fetch_pkg::*;
#(
    parameter int LINES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [29:0]          raddr,
    output logic                 hit,
    output logic [InstBus-1:0]   rdata,
    input  logic                 we,
    input  logic [29:0]          waddr,
    input  logic [InstBus-1:0]   wdata
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [InstBus-1:0] data_q [LINES];
    logic [IDX_W-1:0]   ridx;
    logic [IDX_W-1:0]   widx;

    assign ridx  = raddr[IDX_W-1:0];
    assign widx  = waddr[IDX_W-1:0];
    assign hit   = valid_q[ridx] && (tag_q[ridx] == raddr[29:IDX_W]);
    assign rdata = data_q[ridx];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid_q <= '0;
        end else if (we == WriteEnable) begin
            valid_q[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we == WriteEnable) begin
            tag_q[widx]  <= waddr[29:IDX_W];
            data_q[widx] <= wdata;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles each word from four byte reads (little-endian)
// and holds it for decode; optional I-cache enabled by FETCH_ICACHE_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_rd_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two and at least 2");
    end

    state_e                 state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [2:0]             issue_cnt_q, issue_cnt_d;
    logic [2:0]             recv_cnt_q, recv_cnt_d;
    logic                   granted_q, granted_d;
    logic [2:0][7:0]        byte_q, byte_d;
    logic [InstAddrBus-1:0] pc_out_q, pc_out_d;
    logic [InstBus-1:0]     inst_q, inst_d;
    logic                   valid_q, valid_d;
    logic                   rd_req;
    logic                   last_byte;
    logic [InstBus-1:0]     fill_word;
    logic                   cache_hit;
    logic [InstBus-1:0]     cache_rdata;

    assign last_byte = (state_q == FETCH) && granted_q && (recv_cnt_q == 3'd3);
    assign fill_word = {mem_din_i, byte_q[2], byte_q[1], byte_q[0]};

`ifdef FETCH_ICACHE_EN
    logic lookup_hit;
    logic fill_we;

    if_icache #(.LINES(ICACHE_LINES)) u_icache (
        .clk   (clk),
        .rst   (rst),
        .raddr (pc_q[31:2]),
        .hit   (lookup_hit),
        .rdata (cache_rdata),
        .we    (fill_we),
        .waddr (pc_q[31:2]),
        .wdata (fill_word)
    );

    // Lookup only before any byte of this fetch has gone to memory.
    assign cache_hit = lookup_hit && (state_q == FETCH) &&
                       (issue_cnt_q == 3'd0) && (recv_cnt_q == 3'd0);
    assign fill_we   = last_byte && !branch_flag_i;
`else
    assign cache_hit   = 1'b0;
    assign cache_rdata = ZeroWord;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        granted_d   = 1'b0;
        byte_d      = byte_q;
        pc_out_d    = pc_out_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        rd_req      = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (cache_hit) begin
                    state_d  = HOLD;
                    pc_out_d = pc_q;
                    inst_d   = cache_rdata;
                    valid_d  = 1'b1;
                end else begin
                    rd_req = (issue_cnt_q != 3'd4);
                    if (rd_req && mem_grant_i) begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                        granted_d   = 1'b1;
                    end
                    // The byte on mem_din_i belongs to last cycle's granted issue.
                    if (granted_q) begin
                        recv_cnt_d = recv_cnt_q + 3'd1;
                        if (last_byte) begin
                            state_d  = HOLD;
                            pc_out_d = pc_q;
                            inst_d   = fill_word;
                            valid_d  = 1'b1;
                        end else begin
                            byte_d[recv_cnt_q[1:0]] = mem_din_i;
                        end
                    end
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    pc_d        = pc_q + 32'd4;
                    valid_d     = 1'b0;
                    issue_cnt_d = 3'd0;
                    recv_cnt_d  = 3'd0;
                    state_d     = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything above, including consumption and stall.
        if (branch_flag_i) begin
            pc_d        = word_align(branch_target_i);
            valid_d     = 1'b0;
            issue_cnt_d = 3'd0;
            recv_cnt_d  = 3'd0;
            granted_d   = 1'b0;
            state_d     = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            granted_q   <= 1'b0;
            byte_q      <= '0;
            pc_out_q    <= ZeroWord;
            inst_q      <= ZeroWord;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            granted_q   <= granted_d;
            byte_q      <= byte_d;
            pc_out_q    <= pc_out_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
        end
    end

    assign mem_rd_o     = rd_req;
    assign mem_addr_o   = rd_req ? (pc_q + {29'd0, issue_cnt_q}) : ZeroWord;
    assign pc_o         = pc_out_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a transaction-level model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        grant;
    logic [7:0]  mem_din;
    logic [31:0] mem_addr_o;
    logic        mem_rd_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    if_fetch #(.RESET_PC(32'h0000_0000), .ICACHE_LINES(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .branch_flag_i   (branch),
        .branch_target_i (target),
        .mem_grant_i     (grant),
        .mem_din_i       (mem_din),
        .mem_addr_o      (mem_addr_o),
        .mem_rd_o        (mem_rd_o),
        .pc_o            (pc_o),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int n_vec = 0;
    int n_mis = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endfunction

    // Memory contents: the test program bytes at 0..3, a hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0: return 8'h13;
            32'h1: return 8'h05;
            32'h2: return 8'h10;
            32'h3: return 8'h00;
            default: return ((a[7:0] * 8'd29) + a[15:8] + a[31:24]) ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Memory responder: a byte requested and granted in cycle k appears in k+1.
    logic        s_req;
    logic [31:0] s_addr;
    always @(negedge clk) begin
        s_req  = mem_rd_o && grant;
        s_addr = mem_addr_o;
    end
    always @(posedge clk) begin
        #1;
        if (s_req === 1'b1) mem_din = mem_byte(s_addr);
        else                mem_din = 8'($urandom_range(0, 255));
    end

    // Transaction-level model: which instruction is being fetched or shown,
    // how many of its bytes memory has granted, and whether it is presented.
    logic        m_active = 1'b0;
    logic        m_idle, m_fetch, m_present, m_ret;
    logic [31:0] m_pc;
    int          m_grants;

    always @(negedge clk) begin
        if (m_active) begin
            chk("valid", inst_valid_o, m_present);
            chk("mem_rd", mem_rd_o, m_fetch && (m_grants < 4));
            if (m_fetch && (m_grants < 4)) chk("mem_addr", mem_addr_o, m_pc + m_grants);
            if (m_present) begin
                chk("pc", pc_o, m_pc);
                chk("inst", inst_o, mem_word(m_pc));
            end
        end
        if (rst) begin
            m_active = 1'b1; m_idle = 1'b1; m_fetch = 1'b0; m_present = 1'b0;
            m_ret = 1'b0; m_pc = 32'h0; m_grants = 0;
        end else if (m_active) begin
            if (branch) begin
                m_pc = {target[31:2], 2'b00};
                m_idle = 1'b0; m_fetch = 1'b1; m_present = 1'b0; m_ret = 1'b0; m_grants = 0;
            end else if (m_idle) begin
                m_idle = 1'b0; m_fetch = 1'b1;
            end else if (m_present) begin
                if (!stall) begin
                    m_pc = m_pc + 32'd4; m_present = 1'b0; m_fetch = 1'b1; m_grants = 0;
                end
            end else if (m_fetch) begin
                if (m_ret) begin
                    m_ret = 1'b0; m_fetch = 1'b0; m_present = 1'b1;
                end else if ((m_grants < 4) && grant) begin
                    m_grants++;
                    if (m_grants == 4) m_ret = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (inst_valid_o === 1'b1) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) begin
            n_vec++; n_mis++;
            $display("FAIL %s: inst_valid_o never rose within %0d cycles", name, limit);
        end
    endtask

    task automatic consume_one();
        stall = 1'b0;
        tick();
        stall = 1'b1;
    endtask

    int t_issue, t_valid, t_cons;

    initial begin
        rst = 1'b1; stall = 1'b1; branch = 1'b0; target = 32'h0; grant = 1'b1; mem_din = 8'h00;
        repeat (3) tick();
        chk("rst_valid", inst_valid_o, 1'b0);
        chk("rst_rd", mem_rd_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        rst = 1'b0;

        // First fetch from 0x0 with continuous grant.
        t_issue = -1;
        for (int i = 0; i < 10; i++) begin
            if (mem_rd_o === 1'b1) begin t_issue = cyc; break; end
            tick();
        end
        chk("first_issue_seen", t_issue >= 0, 1'b1);
        for (int b = 0; b < 4; b++) begin
            chk("first_addr", mem_addr_o, b);
            tick();
        end
        wait_valid("first_valid", 20, t_valid);
        chk("first_latency", t_valid - t_issue, 5);
        chk("first_inst", inst_o, 32'h0010_0513);
        chk("first_pc", pc_o, 32'h0);

        // Hold under stall, then consume.
        repeat (3) begin
            tick();
            chk("stall_valid", inst_valid_o, 1'b1);
            chk("stall_pc", pc_o, 32'h0);
            chk("stall_inst", inst_o, 32'h0010_0513);
            chk("stall_rd", mem_rd_o, 1'b0);
        end
        t_cons = cyc;
        consume_one();
        wait_valid("second_valid", 20, t_valid);
        chk("consume_latency", t_valid - t_cons, 6);
        chk("second_pc", pc_o, 32'h4);

        repeat (3) begin
            tick();
            chk("stall2_pc", pc_o, 32'h4);
        end
        consume_one();
        wait_valid("third_valid", 20, t_valid);
        chk("third_pc", pc_o, 32'h8);

        // Grant withheld for two cycles on the second byte of the fetch at 0xC.
        t_cons = cyc;
        consume_one();
        chk("gl_addr0", mem_addr_o, 32'hC);
        tick();
        grant = 1'b0;
        chk("gl_addr1a", mem_addr_o, 32'hD);
        tick();
        chk("gl_addr1b", mem_addr_o, 32'hD);
        tick();
        grant = 1'b1;
        chk("gl_addr1c", mem_addr_o, 32'hD);
        wait_valid("gl_valid", 20, t_valid);
        chk("gl_latency", t_valid - t_cons, 8);
        chk("gl_pc", pc_o, 32'hC);

        // Redirect after two bytes of the fetch at 0x10.
        consume_one();
        tick();
        branch = 1'b1; target = 32'h0000_0103;
        tick();
        branch = 1'b0;
        chk("br_addr", mem_addr_o, 32'h100);
        chk("br_rd", mem_rd_o, 1'b1);
        wait_valid("br_valid", 20, t_valid);
        chk("br_pc", pc_o, 32'h100);

        // Redirect coincident with consumption.
        stall = 1'b0; branch = 1'b1; target = 32'h0000_0200;
        tick();
        stall = 1'b1; branch = 1'b0;
        wait_valid("brc_valid", 20, t_valid);
        chk("brc_pc", pc_o, 32'h200);

        // Redirect during a stall, to the last word; consumption wraps to 0.
        branch = 1'b1; target = 32'hFFFF_FFFE;
        tick();
        branch = 1'b0;
        chk("brs_valid_drop", inst_valid_o, 1'b0);
        wait_valid("wrap_valid", 20, t_valid);
        chk("wrap_top_pc", pc_o, 32'hFFFF_FFFC);
        consume_one();
        wait_valid("wrap_next_valid", 20, t_valid);
        chk("wrap_pc", pc_o, 32'h0);
        chk("wrap_inst", inst_o, 32'h0010_0513);

        // Randomized phase; the per-cycle model does the checking.
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 399) == 0);
            stall = ($urandom_range(0, 2) == 0);
            grant = ($urandom_range(0, 3) != 0);
            branch = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 2))
                0: target = $urandom;
                1: target = 32'($urandom_range(0, 255));
                default: target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            endcase
            tick();
        end
        rst = 1'b0; branch = 1'b0; stall = 1'b0; grant = 1'b1;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
